fifo_sync_param: RTL and testbench

//   Parametrised synchronous FIFO: circular-buffer storage plus internal

---
 rtl/fifo_sync_param.sv | 79 +++++++
 tb/tb_fifo_sync_param.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with internal pointers, occupancy count,
// threshold flags and one-cycle overflow/underflow pulses.
module fifo_sync_param #(
   parameter int DATA_WIDTH      = 12,
   parameter int ADDR_WIDTH      = 3,
   parameter int ALMOST_FULL_TH  = 6,
   parameter int ALMOST_EMPTY_TH = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  wr_en,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  rd_en,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  valid,
   output logic                  full,
   output logic                  empty,
   output logic                  almost_full,
   output logic                  almost_empty,
   output logic [ADDR_WIDTH:0]   count,
   output logic                  overflow,
   output logic                  underflow
);

   localparam int CW = ADDR_WIDTH + 1;
   localparam logic [ADDR_WIDTH:0] DEPTH_C = CW'(2 ** ADDR_WIDTH);
   localparam logic [ADDR_WIDTH:0] AF_TH   = CW'(ALMOST_FULL_TH);
   localparam logic [ADDR_WIDTH:0] AE_TH   = CW'(ALMOST_EMPTY_TH);

   logic [DATA_WIDTH-1:0] mem [2 ** ADDR_WIDTH];
   logic [ADDR_WIDTH-1:0] wr_ptr;
   logic [ADDR_WIDTH-1:0] rd_ptr;
   logic                  rd_ok;
   logic                  wr_ok;

   // A read frees a slot in the same cycle, so a full FIFO still takes a write.
   assign rd_ok = rd_en && !empty;
   assign wr_ok = wr_en && (!full || rd_ok);

   assign full         = (count == DEPTH_C);
   assign empty        = (count == '0);
   assign almost_full  = (count >= AF_TH);
   assign almost_empty = (count <= AE_TH);

   // NOTE: storage has no reset; clearing a RAM array costs a mux per bit and
   // the pointers already guarantee unwritten entries are never read.
   always_ff @(posedge clk) begin
      if (wr_ok) mem[wr_ptr] <= data_in;
   end

   // NOTE: all sequential state uses non-blocking assignments so that the
   // read of mem[rd_ptr] sees the pre-edge value even when wr_ptr == rd_ptr.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         data_out  <= '0;
         valid     <= 1'b0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         valid     <= rd_ok;
         overflow  <= wr_en && !wr_ok;
         underflow <= rd_en && !rd_ok;
         if (rd_ok) begin
            data_out <= mem[rd_ptr];
            rd_ptr   <= rd_ptr + ADDR_WIDTH'(1);
         end
         if (wr_ok) wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
         case ({wr_ok, rd_ok})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_sync_param.sv
// Directed and randomized bench for fifo_sync_param, checked against a
// queue-based model of FIFO behaviour.
module tb_fifo_sync_param;

   logic        clk = 1'b0;
   logic        reset;
   logic        wr_en;
   logic [11:0] data_in;
   logic        rd_en;
   logic [11:0] data_out;
   logic        valid, full, empty, almost_full, almost_empty;
   logic [3:0]  count;
   logic        overflow, underflow;

   fifo_sync_param #(
      .DATA_WIDTH(12), .ADDR_WIDTH(3), .ALMOST_FULL_TH(6), .ALMOST_EMPTY_TH(2)
   ) dut (
      .clk(clk), .reset(reset), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
      .data_out(data_out), .valid(valid), .full(full), .empty(empty),
      .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
      .overflow(overflow), .underflow(underflow)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   logic [11:0] q[$];
   logic [11:0] exp_dout;
   logic        exp_valid, exp_ovf, exp_udf;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   task automatic check_all(input string tag);
      int sz;
      sz = q.size();
      check({tag, ".data_out"}, 32'(data_out), 32'(exp_dout));
      check({tag, ".valid"}, 32'(valid), 32'(exp_valid));
      check({tag, ".count"}, 32'(count), 32'(sz));
      check({tag, ".full"}, 32'(full), 32'(sz == 8));
      check({tag, ".empty"}, 32'(empty), 32'(sz == 0));
      check({tag, ".almost_full"}, 32'(almost_full), 32'(sz >= 6));
      check({tag, ".almost_empty"}, 32'(almost_empty), 32'(sz <= 2));
      check({tag, ".overflow"}, 32'(overflow), 32'(exp_ovf));
      check({tag, ".underflow"}, 32'(underflow), 32'(exp_udf));
   endtask

   // Called at a falling edge: drive, let one rising edge pass, update model, check.
   task automatic cycle(input string tag, input logic w, input logic [11:0] d, input logic r);
      logic rd_acc, wr_acc;
      wr_en   = w;
      data_in = d;
      rd_en   = r;
      rd_acc  = r && (q.size() > 0);
      wr_acc  = w && (q.size() < 8 || rd_acc);
      @(posedge clk);
      exp_valid = rd_acc;
      if (rd_acc) exp_dout = q.pop_front();
      if (wr_acc) q.push_back(d);
      exp_ovf = w && !wr_acc;
      exp_udf = r && !rd_acc;
      @(negedge clk);
      check_all(tag);
   endtask

   task automatic model_reset();
      q.delete();
      exp_dout  = '0;
      exp_valid = 1'b0;
      exp_ovf   = 1'b0;
      exp_udf   = 1'b0;
   endtask

   initial begin
      wr_en   = 1'b0;
      rd_en   = 1'b0;
      data_in = '0;
      reset   = 1'b1;
      model_reset();
      #12;
      check_all("reset_state");
      @(negedge clk);
      reset = 1'b0;

      // Basic write/read ordering
      cycle("t1_wr", 1, 12'h123, 0);
      cycle("t1_wr", 1, 12'hABC, 0);
      cycle("t1_wr", 1, 12'h456, 0);
      cycle("t1_wr", 1, 12'hDEF, 0);
      for (int i = 0; i < 4; i++) cycle("t1_rd", 0, 12'h000, 1);
      check("t1_last_word", 32'(data_out), 32'h0DEF);

      // Fill, overflow, drain
      for (int i = 0; i < 8; i++) cycle("t2_fill", 1, 12'(12'h200 + i), 0);
      cycle("t2_ovf", 1, 12'hFFF, 0);
      check("t2_ovf_count", 32'(count), 32'd8);
      cycle("t2_idle", 0, 12'h000, 0);
      for (int i = 0; i < 8; i++) cycle("t2_drain", 0, 12'h000, 1);
      check("t2_last_word", 32'(data_out), 32'h207);

      // Underflow leaves data_out alone
      cycle("t3_udf", 0, 12'h000, 1);
      check("t3_keep", 32'(data_out), 32'h207);
      cycle("t3_idle", 0, 12'h000, 0);

      // Pointer wrap
      for (int i = 0; i < 6; i++) cycle("t4_wrA", 1, 12'(12'h300 + i), 0);
      for (int i = 0; i < 6; i++) cycle("t4_rdA", 0, 12'h000, 1);
      for (int i = 0; i < 6; i++) cycle("t4_wrB", 1, 12'(12'h010 + i), 0);
      for (int i = 0; i < 6; i++) cycle("t4_rdB", 0, 12'h000, 1);
      check("t4_wrap_last", 32'(data_out), 32'h015);

      // Simultaneous at full and at empty
      for (int i = 0; i < 8; i++) cycle("t5_fill", 1, 12'(12'h400 + i), 0);
      cycle("t5_both_full", 1, 12'h4AA, 1);
      check("t5_oldest", 32'(data_out), 32'h400);
      for (int i = 0; i < 8; i++) cycle("t5_drain", 0, 12'h000, 1);
      check("t5_new_word", 32'(data_out), 32'h4AA);
      cycle("t5_both_empty", 1, 12'h5BB, 1);
      check("t5_udf", 32'(underflow), 32'd1);
      cycle("t5_rd", 0, 12'h000, 1);
      check("t5_read_back", 32'(data_out), 32'h5BB);

      // Asynchronous reset mid-cycle
      for (int i = 0; i < 5; i++) cycle("t6_fill", 1, 12'(12'h600 + i), 0);
      cycle("t6_rd", 0, 12'h000, 1);
      cycle("t6_wr", 1, 12'h6FF, 0);
      wr_en = 1'b0;
      rd_en = 1'b0;
      #2 reset = 1'b1;
      model_reset();
      #1 check_all("t6_async");
      @(negedge clk);
      reset = 1'b0;
      cycle("t6_post_udf", 0, 12'h000, 1);

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         logic w, r;
         w = ($urandom_range(99) < 55);
         r = ($urandom_range(99) < 45);
         cycle("rand", w, 12'($urandom), r);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
